// File: rtl/dac_output_stage.sv
// dac_output_stage
//   Output stage between the voice mixer and the DAC. One frame of signed
//   samples (one per channel) is accepted per valid/ready handshake. Each
//   channel is scaled by an unsigned Q1.(GAIN_WIDTH-1) gain, rounded and
//   saturated to OUT_WIDTH bits, and flagged in a sticky clip bit if it
//   saturated. The frame is then presented as parallel offset-binary words
//   and as a framed two's-complement serial bitstream.
//
//   Build option: define DAC_DITHER_EN to replace the fixed round-half-up
//   constant with bits from a 16-bit LFSR (seed 0xACE1, taps 16,14,13,11).
//
// Ports
//   clk           system clock
//   reset         synchronous active-low reset
//   sample_in     CHANNELS x IN_WIDTH signed samples, channel 0 in LSBs
//   sample_valid  frame valid
//   sample_ready  stage idle; frame accepted on valid & ready
//   gain          CHANNELS x GAIN_WIDTH unsigned gains, captured with the frame
//   clip_clear    clears all sticky clip flags (a simultaneous set wins)
//   clip          sticky per-channel saturation flags
//   dac_out       CHANNELS x OUT_WIDTH offset-binary words, channel 0 in LSBs
//   dac_sclk      serial bit clock, idles low
//   dac_fs        frame sync, high during bit 0 of channel 0
//   dac_sdata     serial data, MSB first, channel 0 first
//
// state | meaning
// IDLE  | sample_ready high, waiting for a frame
// SCALE | one channel scaled/rounded/saturated per cycle, ascending index
// SHIFT | dac_out updated; CHANNELS*OUT_WIDTH bits being serialised

module dac_output_stage #(
   parameter int IN_WIDTH   = 24,
   parameter int OUT_WIDTH  = 16,
   parameter int CHANNELS   = 2,
   parameter int GAIN_WIDTH = 8,
   parameter int CLK_DIV    = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [CHANNELS*IN_WIDTH-1:0]     sample_in,
   input  logic                             sample_valid,
   output logic                             sample_ready,
   input  logic [CHANNELS*GAIN_WIDTH-1:0]   gain,
   input  logic                             clip_clear,
   output logic [CHANNELS-1:0]              clip,
   output logic [CHANNELS*OUT_WIDTH-1:0]    dac_out,
   output logic                             dac_sclk,
   output logic                             dac_fs,
   output logic                             dac_sdata
);

   localparam int PW    = IN_WIDTH + GAIN_WIDTH + 1;
   localparam int RSH   = IN_WIDTH - OUT_WIDTH;
   localparam int NBITS = CHANNELS * OUT_WIDTH;
   localparam int CW    = $clog2(CHANNELS > 1 ? CHANNELS : 2);
   localparam int BW    = $clog2(NBITS > 1 ? NBITS : 2);
   localparam int DW    = $clog2(CLK_DIV > 1 ? CLK_DIV : 2);

   localparam logic signed [PW-1:0]  MAXV    = (PW'(1) << (OUT_WIDTH-1)) - PW'(1);
   localparam logic signed [PW-1:0]  MINV    = -MAXV - PW'(1);
   localparam logic [OUT_WIDTH-1:0]  MID     = OUT_WIDTH'(1) << (OUT_WIDTH-1);
   localparam logic [CW-1:0]         CH_LAST = CW'(CHANNELS-1);
   localparam logic [BW-1:0]         BIT_MAX = BW'(NBITS-1);
   localparam logic [DW-1:0]         PH_MAX  = DW'(CLK_DIV-1);

   typedef enum logic [1:0] {IDLE, SCALE, SHIFT} state_t;

   state_t                          state, state_nxt;
   logic                            ready_q;
   logic [CHANNELS*IN_WIDTH-1:0]    samp_q;
   logic [CHANNELS*GAIN_WIDTH-1:0]  gain_q;
   logic [CW-1:0]                   ch_idx;
   logic [NBITS-1:0]                stage_word;
   logic [CHANNELS-1:0]             stage_clip;
   logic [NBITS-1:0]                dac_q;
   logic [CHANNELS-1:0]             clip_q;
   logic [NBITS-1:0]                sreg;
   logic [BW-1:0]                   bit_cnt;
   logic [DW-1:0]                   phase_cnt;
   logic                            sclk_q, fs_q, sdata_q;

   logic                            accept, commit, sclk_rise, bit_next, frame_done;

   logic signed [IN_WIDTH-1:0]      cur_sample;
   logic [GAIN_WIDTH-1:0]           cur_gain;
   logic signed [PW-1:0]            sx, gx, prod, scaled, rounded;
   logic signed [PW-1:0]            rnd_const;
   logic [OUT_WIDTH-1:0]            sat_word;
   logic                            sat_flag;
   logic [NBITS-1:0]                word_all, offset_all, ordered;
   logic [CHANNELS-1:0]             clip_all, clip_nxt;

   // ---------------- rounding constant ----------------
`ifdef DAC_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (!reset)
         lfsr <= 16'hACE1;
      else if (state == SCALE)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   always_comb begin
      rnd_const = '0;
      for (int i = 0; i < RSH; i++)
         rnd_const[i] = lfsr[i % 16];
   end
`else
   assign rnd_const = PW'(1) << (RSH-1);
`endif

   // ---------------- per-channel arithmetic ----------------
   always_comb begin
      cur_sample = samp_q[int'(ch_idx)*IN_WIDTH +: IN_WIDTH];
      cur_gain   = gain_q[int'(ch_idx)*GAIN_WIDTH +: GAIN_WIDTH];
      sx         = PW'(cur_sample);
      gx         = PW'({1'b0, cur_gain});
      prod       = sx * gx;
      scaled     = prod >>> (GAIN_WIDTH-1);
      rounded    = (scaled + rnd_const) >>> RSH;
      sat_flag   = 1'b0;
      if (rounded > MAXV) begin
         sat_word = {1'b0, {(OUT_WIDTH-1){1'b1}}};
         sat_flag = 1'b1;
      end else if (rounded < MINV) begin
         sat_word = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         sat_flag = 1'b1;
      end else begin
         sat_word = rounded[OUT_WIDTH-1:0];
      end
   end

   // Staged frame including the channel being processed this cycle, so the
   // last channel can be committed together with the earlier ones.
   always_comb begin
      word_all = stage_word;
      clip_all = stage_clip;
      word_all[int'(ch_idx)*OUT_WIDTH +: OUT_WIDTH] = sat_word;
      clip_all[ch_idx] = sat_flag;
      offset_all = '0;
      ordered    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         offset_all[c*OUT_WIDTH +: OUT_WIDTH] = word_all[c*OUT_WIDTH +: OUT_WIDTH] ^ MID;
         // channel 0 occupies the top of the shift register so it leaves first
         ordered[(CHANNELS-1-c)*OUT_WIDTH +: OUT_WIDTH] = word_all[c*OUT_WIDTH +: OUT_WIDTH];
      end
      clip_nxt = clip_clear ? '0 : clip_q;
      if (commit)
         clip_nxt = clip_nxt | clip_all;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      commit     = 1'b0;
      sclk_rise  = 1'b0;
      bit_next   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (sample_valid && ready_q) begin
               accept    = 1'b1;
               state_nxt = SCALE;
            end
         end
         SCALE: begin
            if (ch_idx == CH_LAST) begin
               commit    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (phase_cnt == '0) begin
               if (!sclk_q) begin
                  sclk_rise = 1'b1;
               end else if (bit_cnt == '0) begin
                  frame_done = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  bit_next = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath and serial timers ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         ready_q    <= 1'b0;
         samp_q     <= '0;
         gain_q     <= '0;
         ch_idx     <= '0;
         stage_word <= '0;
         stage_clip <= '0;
         dac_q      <= {CHANNELS{MID}};
         clip_q     <= '0;
         sreg       <= '0;
         bit_cnt    <= '0;
         phase_cnt  <= '0;
         sclk_q     <= 1'b0;
         fs_q       <= 1'b0;
         sdata_q    <= 1'b0;
      end else begin
         // registered so that ready stays low for the whole reset period
         ready_q <= (state_nxt == IDLE);
         clip_q  <= clip_nxt;

         if (accept) begin
            samp_q <= sample_in;
            gain_q <= gain;
            ch_idx <= '0;
         end

         if (state == SCALE) begin
            stage_word <= word_all;
            stage_clip <= clip_all;
            ch_idx     <= ch_idx + CW'(1);
         end

         if (commit) begin
            dac_q     <= offset_all;
            sreg      <= ordered;
            sdata_q   <= ordered[NBITS-1];
            fs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            phase_cnt <= PH_MAX;
            bit_cnt   <= BIT_MAX;
         end else if (sclk_rise) begin
            sclk_q    <= 1'b1;
            phase_cnt <= PH_MAX;
         end else if (bit_next) begin
            sclk_q    <= 1'b0;
            fs_q      <= 1'b0;
            sdata_q   <= sreg[NBITS-2];
            sreg      <= sreg << 1;
            bit_cnt   <= bit_cnt - BW'(1);
            phase_cnt <= PH_MAX;
         end else if (frame_done) begin
            sclk_q  <= 1'b0;
            fs_q    <= 1'b0;
            sdata_q <= 1'b0;
         end else if (state == SHIFT) begin
            phase_cnt <= phase_cnt - DW'(1);
         end
      end
   end

   assign sample_ready = ready_q;
   assign clip         = clip_q;
   assign dac_out      = dac_q;
   assign dac_sclk     = sclk_q;
   assign dac_fs       = fs_q;
   assign dac_sdata    = sdata_q;

endmodule

// File: tb/tb_dac_output_stage.sv
// Testbench for dac_output_stage: table-driven frames with a scoreboard of
// expected frames consumed by a serial/parallel monitor, plus hand-written
// sequences for clip stickiness, back-pressure and mid-frame reset.

module tb_dac_output_stage;

   localparam int CLK_DIV = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [47:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] gain;
   logic        clip_clear;
   logic [1:0]  clip;
   logic [31:0] dac_out;
   logic        dac_sclk, dac_fs, dac_sdata;

   dac_output_stage #(.CLK_DIV(CLK_DIV)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .gain         (gain),
      .clip_clear   (clip_clear),
      .clip         (clip),
      .dac_out      (dac_out),
      .dac_sclk     (dac_sclk),
      .dac_fs       (dac_fs),
      .dac_sdata    (dac_sdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] s0, s1;
      logic [7:0]  g0, g1;
      logic [31:0] dac;
      logic [1:0]  clip;
   } vec_t;

   typedef struct {
      logic [31:0] dac;
      logic [1:0]  clip;
   } exp_t;

   exp_t        exp_q[$];
   vec_t        vecs[9];
   int          errors = 0;
   int          checks = 0;
   logic [1:0]  sticky = 2'b00;
   logic [31:0] last_dac = 32'h8000_8000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference model: r = floor((sample*gain + 2^14) / 2^15), then saturate.
   function automatic void model(input logic [23:0] smp, input logic [7:0] g,
                                 output logic [15:0] w, output logic c);
      longint p, r;
      p = longint'($signed(smp)) * longint'(g);
      r = (p + 64'sd16384) >>> 15;
      if (r > 32767) begin
         w = 16'hFFFF; c = 1'b1;
      end else if (r < -32768) begin
         w = 16'h0000; c = 1'b1;
      end else begin
         w = 16'(r) ^ 16'h8000; c = 1'b0;
      end
   endfunction

   // ---------------- serial / parallel monitor ----------------
   int          bit_idx = 0;
   int          cyc = 0;
   int          last_rise = 0;
   int          period_bad = 0;
   logic        sclk_prev = 1'b0;
   logic        unexpected = 1'b0;
   logic [31:0] sword, fs_vec, exp_ser;

   always @(negedge clk) begin
      cyc++;
      if (reset !== 1'b1) begin
         bit_idx   = 0;
         sclk_prev = 1'b0;
      end else begin
         if (dac_sclk && !sclk_prev) begin
            if (bit_idx == 0) begin
               period_bad = 0;
               unexpected = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  unexpected = 1'b1;
                  $display("FAIL serial_unexpected: frame started with dac_out %0h and no expectation", dac_out);
               end else begin
                  chk("mon_dac", dac_out, exp_q[0].dac);
                  chk("mon_clip", clip, exp_q[0].clip);
               end
            end else if (cyc - last_rise != 2*CLK_DIV) begin
               period_bad++;
            end
            last_rise = cyc;
            sword  = {sword[30:0], dac_sdata};
            fs_vec = {fs_vec[30:0], dac_fs};
            bit_idx++;
            if (bit_idx == 32) begin
               bit_idx = 0;
               if (!unexpected) begin
                  exp_ser = {exp_q[0].dac[15:0] ^ 16'h8000, exp_q[0].dac[31:16] ^ 16'h8000};
                  chk("serial_word", sword, exp_ser);
                  chk("fs_pattern", fs_vec, 32'h8000_0000);
                  chk("bit_period_errs", period_bad, 0);
                  void'(exp_q.pop_front());
               end
            end
         end
         sclk_prev = dac_sclk;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(output logic ok);
      int n = 0;
      while (sample_ready !== 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (sample_ready === 1'b1);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: sample_ready %b after %0d cycles, required 1", sample_ready, n);
      end
   endtask

   // Drives one frame and returns #1 after the accepting edge.
   task automatic send_frame(input vec_t v, input logic hold, output logic ok);
      exp_t e;
      wait_ready(ok);
      if (ok) begin
         sample_in    = {v.s1, v.s0};
         gain         = {v.g1, v.g0};
         sample_valid = 1'b1;
         @(posedge clk); #1;
         sample_valid = hold;
         sticky       = sticky | v.clip;
         e.dac        = v.dac;
         e.clip       = sticky;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_timing(input logic [31:0] exp_dac);
      chk("ready_drop", sample_ready, 1'b0);
      @(posedge clk); #1;
      chk("dac_hold", dac_out, last_dac);
      @(posedge clk); #1;
      chk("dac_update", dac_out, exp_dac);
      chk("clip_update", clip, sticky);
      last_dac = exp_dac;
      repeat (127) @(posedge clk); #1;
      chk("ready_low_129", sample_ready, 1'b0);
      @(posedge clk); #1;
      chk("ready_back_130", sample_ready, 1'b1);
   endtask

   task automatic do_clip_clear();
      clip_clear = 1'b1;
      @(posedge clk); #1;
      clip_clear = 1'b0;
      sticky = 2'b00;
      chk("clip_cleared", clip, 2'b00);
   endtask

   task automatic run_vec(input vec_t v);
      logic ok;
      send_frame(v, 1'b0, ok);
      if (ok) check_timing(v.dac);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic        ok;
      vec_t        v, vb;
      logic [15:0] w0, w1;
      logic        c0, c1;
      int          n;

      //           s0          s1          g0     g1     dac            clip
      vecs[0] = '{24'h123480, 24'hFFFF00, 8'h80, 8'h80, 32'h7FFF_9235, 2'b00};
      vecs[1] = '{24'h7FFFFF, 24'h800000, 8'hFF, 8'hFF, 32'h0000_FFFF, 2'b11};
      vecs[2] = '{24'h7FFFFF, 24'h800000, 8'h00, 8'h00, 32'h8000_8000, 2'b00};
      vecs[3] = '{24'h000000, 24'h000000, 8'h80, 8'h80, 32'h8000_8000, 2'b00};
      vecs[4] = '{24'h00007F, 24'h000080, 8'h80, 8'h80, 32'h8001_8000, 2'b00};
      vecs[5] = '{24'hFFFF80, 24'hFFFF7F, 8'h80, 8'h80, 32'h7FFF_8000, 2'b00};
      vecs[6] = '{24'h7FFF7F, 24'h7FFF80, 8'h80, 8'h80, 32'hFFFF_FFFF, 2'b10};
      vecs[7] = '{24'h800000, 24'h800000, 8'h80, 8'h81, 32'h0000_0000, 2'b10};
      vecs[8] = '{24'h100000, 24'hF00000, 8'h40, 8'hC0, 32'h6800_8800, 2'b00};

      reset        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      gain         = '0;
      clip_clear   = 1'b0;

      // reset
      repeat (3) @(posedge clk); #1;
      chk("rst_dac", dac_out, 32'h8000_8000);
      chk("rst_clip", clip, 2'b00);
      chk("rst_serial", {dac_sclk, dac_fs, dac_sdata}, 3'b000);
      chk("rst_ready", sample_ready, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", sample_ready, 1'b1);

      // table-driven frames
      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
         if (i == 2) do_clip_clear();
      end

      // random frames against the model
      for (int k = 0; k < 4; k++) begin
         v.s0 = 24'($urandom);
         v.s1 = 24'($urandom);
         v.g0 = 8'($urandom_range(0, 255));
         v.g1 = 8'($urandom_range(0, 255));
         model(v.s0, v.g0, w0, c0);
         model(v.s1, v.g1, w1, c1);
         v.dac  = {w1, w0};
         v.clip = {c1, c0};
         run_vec(v);
      end

      // clip_clear held across a clipping commit: set wins
      clip_clear = 1'b1;
      sticky     = 2'b00;
      send_frame(vecs[7], 1'b0, ok);
      if (ok) begin
         @(posedge clk); #1;
         chk("clear_held_clip", clip, 2'b00);
         @(posedge clk); #1;
         chk("set_wins_clip", clip, 2'b10);
         chk("set_wins_dac", dac_out, vecs[7].dac);
         last_dac = vecs[7].dac;
      end
      clip_clear = 1'b0;
      wait_ready(ok);
      do_clip_clear();

      // back-pressure: valid held high with different data during the frame
      vb = vecs[8];
      send_frame(vecs[0], 1'b1, ok);
      if (ok) begin
         sample_in = {vb.s1, vb.s0};
         gain      = {vb.g1, vb.g0};
         n = 1;
         while (sample_ready !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
         end
         chk("bp_ready_cycle", n, 131);
         @(posedge clk); #1;
         sample_valid = 1'b0;
         chk("bp_accept", sample_ready, 1'b0);
         chk("bp_dac_a", dac_out, vecs[0].dac);
         exp_q.push_back('{vb.dac, sticky});
         repeat (2) @(posedge clk); #1;
         chk("bp_dac_b", dac_out, vb.dac);
         last_dac = vb.dac;
         wait_ready(ok);
      end

      // reset in the middle of SHIFT
      send_frame(vecs[0], 1'b0, ok);
      if (ok) begin
         repeat (52) @(posedge clk); #1;
         reset = 1'b0;
         exp_q.delete();
         @(posedge clk); #1;
         chk("midrst_dac", dac_out, 32'h8000_8000);
         chk("midrst_clip", clip, 2'b00);
         chk("midrst_serial", {dac_sclk, dac_fs, dac_sdata}, 3'b000);
         chk("midrst_ready", sample_ready, 1'b0);
         reset    = 1'b1;
         sticky   = 2'b00;
         last_dac = 32'h8000_8000;
         @(posedge clk); #1;
         chk("midrst_ready_back", sample_ready, 1'b1);
         run_vec(vecs[8]);
      end

      // drain the scoreboard
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dac_output_stage.md
# dac_output_stage

Multi-channel output stage between the voice mixer and the DAC. It accepts one frame of signed mixed samples per handshake and, per channel:
- applies a programmable gain;
- rounds and saturates to the DAC width, raising sticky clip flags.

It then presents the result both as parallel offset-binary words and as a framed serial bitstream. It generalises the fixed `[23:8] + 32768` truncation with parametrised widths and channel count, gain, saturation and serial output.

## Interface
- IN_WIDTH, 24, signed input sample width per channel (must exceed OUT_WIDTH)
- OUT_WIDTH, 16, DAC word width per channel
- CHANNELS, 2, number of channels (≥1)
- GAIN_WIDTH, 8, unsigned gain width, format Q1.(GAIN_WIDTH-1); 2^(GAIN_WIDTH-1) = unity
- CLK_DIV, 4, clk cycles per half-period of dac_sclk (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  one clock; reset is synchronous and active-low
- sample_in  in  CHANNELS*IN_WIDTH  signed samples, channel 0 in LSBs
- sample_valid  in  1  frame valid
- sample_ready  out  1  stage idle, frame accepted on valid&ready
- gain  in  CHANNELS*GAIN_WIDTH  per-channel gain, sampled with the frame
- clip_clear  in  1  clears all clip flags
- clip  out  CHANNELS  sticky per-channel saturation flags
- dac_out  out  CHANNELS*OUT_WIDTH  parallel offset-binary words, channel 0 in LSBs
- dac_sclk  out  1  serial bit clock, idles low
- dac_fs  out  1  frame sync, high during first bit of channel 0
- dac_sdata  out  1  serial two's-complement data, MSB first, channel 0 first

## Operation
- FSM states: IDLE, SCALE, SHIFT.
  - IDLE: sample_ready=1. valid&ready captures sample_in and gain, then enters SCALE.
  - SCALE: processes one channel per cycle, ascending index. After channel CHANNELS-1, updates all of dac_out at once and enters SHIFT.
  - SHIFT: serialises CHANNELS*OUT_WIDTH bits, then returns to IDLE.
- Arithmetic per channel, with no intermediate truncation:
  - p = sample × gain, signed, IN_WIDTH+GAIN_WIDTH+1 bits;
  - s = p >>> (GAIN_WIDTH-1), arithmetic shift;
  - r = (s + 2^(IN_WIDTH-OUT_WIDTH-1)) >>> (IN_WIDTH-OUT_WIDTH);
  - r saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Saturation sets clip[ch]. Clip flags are sticky until clip_clear. If a set and clip_clear occur in the same cycle, set wins.
- Parallel word = saturated value with MSB inverted (offset binary); 0 maps to 2^(OUT_WIDTH-1). The serial stream carries the same value in two's complement.
- Serial:
  - each bit: dac_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles;
  - dac_sdata and dac_fs change only on entry to the low phase and are stable at the rising edge;
  - dac_fs is high for exactly the first bit of the frame.
- sample_valid during SCALE/SHIFT is ignored. Nothing is captured and nothing is queued.
- Gain 0 yields a midscale word with no clip.

## Timing
- Reset values:
  - sample_ready=0, rising to 1 on the first clk with reset high;
  - clip=0;
  - dac_out = 2^(OUT_WIDTH-1) per channel (silence);
  - dac_sclk=0, dac_fs=0, dac_sdata=0;
  - FSM in IDLE.
- Accept on edge 0. SCALE occupies cycles 1..CHANNELS. dac_out and clip are valid from cycle CHANNELS+1, which is also the first low phase of the serial bit 0.
- SHIFT lasts CHANNELS*OUT_WIDTH*2*CLK_DIV cycles. sample_ready is high again at cycle CHANNELS+1+CHANNELS*OUT_WIDTH*2*CLK_DIV.
- dac_out holds its value until the next frame's update.
- Reset mid-frame: abort on that edge and apply all reset values. No partial dac_out update occurs.

## Configuration
- DAC_DITHER_EN defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset) advances once per SCALE cycle;
  - its low IN_WIDTH-OUT_WIDTH bits replace the rounding constant;
  - saturation and clip rules are unchanged.
- Undefined: fixed round-half-up constant as above, no LFSR logic.

## Test plan
Defaults for all tests except CLK_DIV=2; DAC_DITHER_EN undefined.
- Reset: hold reset=0 for 3 cycles, then release. Required: dac_out=0x8000_8000, clip=0, serial outputs 0, and sample_ready=1 one cycle after release.
- Unity gain: gain=0x80_80, ch0=0x123480, ch1=0xFFFF00. Required: dac_out=0x7FFF_9235 at cycle 3, clip=0.
- Saturation: gain=0xFF_FF, ch0=0x7FFFFF, ch1=0x800000. Required: dac_out=0x0000_FFFF and clip=2'b11. clip stays set over the next frame with gain 0 (dac_out=0x8000_8000). After a clip_clear pulse, clip=0.
- Serial: using the unity-gain frame, capture the 32 bits on dac_sclk rising edges. Required: 0x1235 then 0xFFFF, dac_fs high only for bit 0, bit period 4 cycles, sample_ready back at cycle 131.
- Back-pressure: hold sample_valid high with different data during SHIFT. Required: no capture until sample_ready; the second frame is captured on the first ready cycle.
- Reset mid-frame: assert reset at cycle 50 of SHIFT. Required: next cycle shows all reset values; a new frame afterwards serialises correctly from bit 0.
